uart_boot_ctrl: RTL

//  Sequences the UART receive datapath between boot and run phases. At boot it takes a

---
 rtl/uart_boot_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/uart_boot_ctrl.sv
// UART receive sequencer: loads a length-prefixed program into imem at boot,
// then releases the core and buffers run-phase bytes in a first-word-fall-through FIFO.
module uart_boot_ctrl #(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_ferr,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic [7:0]        in_data,
  output logic              in_empty,
  input  logic              in_pop,
  output logic              err_ferr,
  output logic              err_ovf,
  output logic              err_len
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam logic [32:0] MAX_LEN = 33'd1 << ADDR_W;

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_CHK  = 3'd1,
    S_DATA = 3'd2,
    S_RUN  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [1:0]        byte_cnt;
  logic [31:0]       shreg;
  logic [31:0]       len_q;
  logic [ADDR_W-1:0] wr_addr;
  logic              accept;
  logic              last_write;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              push_req;
  logic              pop_ok;
  logic              push_ok;

  assign accept     = rx_valid && !rx_ferr;
  assign last_write = imem_we && (32'(imem_addr) == (len_q - 32'd1));

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_LEN;
    else       state <= state_next;
  end

  // Next-state logic; the write cycle of the last word is the final DATA cycle
  always_comb begin
    state_next = state;
    case (state)
      S_LEN:  if (accept && byte_cnt == 2'd3) state_next = S_CHK;
      S_CHK: begin
        if (shreg == 32'd0)              state_next = S_RUN;
        else if ({1'b0, shreg} > MAX_LEN) state_next = S_ERR;
        else                              state_next = S_DATA;
      end
      S_DATA: if (last_write) state_next = S_RUN;
      default: state_next = state;
    endcase
  end

  // Header/word assembly, imem write port, run release and sticky boot errors
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_cnt   <= 2'd0;
      shreg      <= 32'd0;
      len_q      <= 32'd0;
      wr_addr    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      cpu_run    <= 1'b0;
      err_ferr   <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (rx_valid && rx_ferr) err_ferr <= 1'b1;
      if ((state == S_LEN || state == S_DATA) && accept) begin
        shreg    <= {shreg[23:0], rx_data};
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (state == S_CHK) begin
        len_q <= shreg;
        if (state_next == S_ERR) err_len <= 1'b1;
      end
      if (state == S_DATA && accept && byte_cnt == 2'd3) begin
        imem_we    <= 1'b1;
        imem_addr  <= wr_addr;
        imem_wdata <= {shreg[23:0], rx_data};
        wr_addr    <= wr_addr + ADDR_W'(1);
      end
      if (state_next == S_RUN) cpu_run <= 1'b1;
    end
  end

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign push_req = (state == S_RUN) && accept;
  assign pop_ok   = in_pop && !in_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the byte
  assign push_ok  = push_req && (!full || pop_ok);

  // Run-phase input FIFO
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'd0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_ovf <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= rx_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
      else if (!push_ok && pop_ok) count <= count - CNT_W'(1);
      if (push_req && full && !pop_ok) err_ovf <= 1'b1;
    end
  end

  assign in_data  = mem[rd_ptr];
  assign in_empty = (count == '0);

endmodule
